digit_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that sits directly upstream of the 3-to-8 decoder (inputs a[2:0], en; output y[7:0]) in the display path. It steps a 3-bit digit index through the enabled digits at a programmable dwell rate and drives the decoder's enable so exactly one digit select is active at a time. Optional blanking gaps between digits suppress ghosting on multiplexed LED displays.

---
 rtl/digit_scan_ctrl_pkg.sv | 15 +
 rtl/digit_scan_ctrl_next_sel.sv | 30 +++
 rtl/digit_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and defaults for the digit scan controller.
// Optional blanking gaps are enabled with SCAN_BLANK_EN.
package digit_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam int DEF_DIV_MAX   = 49999;
  localparam int DEF_BLANK_CYC = 4;
  localparam int NUM_DIGITS    = 8;

endpackage

// File: rtl/digit_scan_ctrl_next_sel.sv
// Rotated priority search: first enabled digit after cur,
// wrapping through cur itself as the last candidate.
module scan_next_sel
  import digit_scan_ctrl_pkg::*;
(
  input  logic [2:0] cur,
  input  logic [7:0] mask,
  output logic [2:0] nxt,
  output logic       valid,
  output logic       wrap
);

  logic [2:0] w_j;

  // Walk from the farthest candidate down so the nearest one wins.
  always_comb begin
    nxt   = cur;
    valid = 1'b0;
    w_j   = cur;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      w_j = cur + 3'(k);
      if (mask[w_j]) begin
        nxt   = w_j;
        valid = 1'b1;
      end
    end
    wrap = valid && (nxt <= cur);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scan controller feeding a 3-to-8 decoder.
// Define SCAN_BLANK_EN to insert blanking gaps before each advance.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DIV_MAX   = DEF_DIV_MAX,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] digit_mask,
  output logic [2:0] a,
  output logic       en,
  output logic       tick,
  output logic       frame
);

  if (BLANK_CYC < 1 || DIV_MAX >= (1 << DIV_W)) begin : g_bad_cfg
    $error("digit_scan_ctrl: bad parameters");
  end

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic             r_entry;
  logic [2:0]       r_a;
  logic             r_en;
  logic             r_tick;
  logic             r_frame;

  logic [2:0] w_nxt;
  logic       w_valid;
  logic       w_wrap;
  logic       w_div_end;
  logic       w_skip;

`ifdef SCAN_BLANK_EN
  localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  logic [BLK_W-1:0] r_blk;
  logic             w_blk_end;
  assign w_blk_end = (r_blk == BLK_W'(BLANK_CYC - 1));
`endif

  scan_next_sel u_sel (
    .cur   (r_a),
    .mask  (digit_mask),
    .nxt   (w_nxt),
    .valid (w_valid),
    .wrap  (w_wrap)
  );

  assign w_div_end = (r_div == DIV_W'(DIV_MAX));
  // A masked-off start digit is skipped on the first SHOW cycle.
  assign w_skip    = r_entry & ~digit_mask[r_a] & w_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_entry <= 1'b0;
      r_a     <= 3'd0;
      r_en    <= 1'b0;
      r_tick  <= 1'b0;
      r_frame <= 1'b0;
`ifdef SCAN_BLANK_EN
      r_blk   <= '0;
`endif
    end else begin
      r_tick  <= 1'b0;
      r_frame <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_en    <= 1'b0;
          r_entry <= 1'b0;
          if (run) begin
            r_state <= ST_SHOW;
            r_div   <= '0;
            r_entry <= 1'b1;
          end
        end
        ST_SHOW: begin
          r_entry <= 1'b0;
          if (!run) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_div   <= '0;
          end else if (w_skip) begin
            r_a     <= w_nxt;
            r_tick  <= 1'b1;
            r_frame <= w_wrap;
            r_en    <= digit_mask[w_nxt];
            r_div   <= '0;
          end else if (w_div_end) begin
            r_div <= '0;
`ifdef SCAN_BLANK_EN
            r_state <= ST_BLANK;
            r_blk   <= '0;
            r_en    <= 1'b0;
`else
            r_en <= digit_mask[w_nxt];
            if (w_valid) begin
              r_a     <= w_nxt;
              r_tick  <= 1'b1;
              r_frame <= w_wrap;
            end
`endif
          end else begin
            r_div <= r_div + DIV_W'(1);
            r_en  <= digit_mask[r_a];
          end
        end
`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          r_en <= 1'b0;
          if (!run) begin
            r_state <= ST_IDLE;
          end else if (w_blk_end) begin
            r_state <= ST_SHOW;
            r_en    <= digit_mask[w_nxt];
            if (w_valid) begin
              r_a     <= w_nxt;
              r_tick  <= 1'b1;
              r_frame <= w_wrap;
            end
          end else begin
            r_blk <= r_blk + BLK_W'(1);
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign a     = r_a;
  assign en    = r_en;
  assign tick  = r_tick;
  assign frame = r_frame;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with DIV_MAX=3, BLANK_CYC=2.
// Expectations follow SCAN_BLANK_EN when it is defined.
module tb_digit_scan_ctrl;

`ifdef SCAN_BLANK_EN
  localparam int FIRST = 7;
  localparam int PER   = 6;
  localparam int LOWS  = 2;
`else
  localparam int FIRST = 5;
  localparam int PER   = 4;
  localparam int LOWS  = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] digit_mask;
  logic [2:0] a;
  logic       en;
  logic       tick;
  logic       frame;
  logic [7:0] y;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign y = en ? (8'd1 << a) : 8'h00;

  digit_scan_ctrl #(
    .DIV_W     (4),
    .DIV_MAX   (3),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .digit_mask (digit_mask),
    .a          (a),
    .en         (en),
    .tick       (tick),
    .frame      (frame)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until tick; n = cycles taken, lows = en-low cycles before it.
  task automatic wait_tick(output int n, output int lows);
    n    = 0;
    lows = 0;
    do begin
      step();
      n++;
      if (!tick && !en) lows++;
    end while (!tick && n < 40);
    chk("tick_seen", int'(tick), 1);
  endtask

  int n, lows, ticks, ens;
  int exp_a[3];
  int exp_f[3];

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    digit_mask = 8'h00;
    repeat (3) step();
    chk("rst_a", int'(a), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_frame", int'(frame), 0);
    rst_n = 1'b1;
    step();

    // full scan
    digit_mask = 8'hFF;
    run        = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wait_tick(n, lows);
      chk($sformatf("full_a%0d", i), int'(a), i % 8);
      chk($sformatf("full_frame%0d", i), int'(frame), (i == 8) ? 1 : 0);
      chk($sformatf("full_en%0d", i), int'(en), 1);
      chk($sformatf("full_per%0d", i), n, (i == 1) ? FIRST : PER);
      if (i > 1) chk($sformatf("full_lows%0d", i), lows, LOWS);
    end
    run = 1'b0;
    step();
    chk("stop_en", int'(en), 0);
    step();

    // sparse mask
    exp_a      = '{2, 7, 0};
    exp_f      = '{0, 0, 1};
    digit_mask = 8'b1000_0101;
    run        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tick(n, lows);
      chk($sformatf("sparse_a%0d", i), int'(a), exp_a[i]);
      chk($sformatf("sparse_frame%0d", i), int'(frame), exp_f[i]);
      chk($sformatf("sparse_per%0d", i), n, (i == 0) ? FIRST : PER);
    end
    run = 1'b0;
    step();
    step();

    // masked start digit
    digit_mask = 8'b0001_0000;
    run        = 1'b1;
    wait_tick(n, lows);
    chk("mstart_n", n, 2);
    chk("mstart_a", int'(a), 4);
    chk("mstart_frame", int'(frame), 0);
    chk("mstart_en", int'(en), 1);
    for (int i = 0; i < 2; i++) begin
      wait_tick(n, lows);
      chk($sformatf("self_a%0d", i), int'(a), 4);
      chk($sformatf("self_per%0d", i), n, PER);
      chk($sformatf("self_frame%0d", i), int'(frame), 1);
    end

    // async reset mid-SHOW
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a", int'(a), 0);
    chk("arst_en", int'(en), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_frame", int'(frame), 0);
    chk("arst_y", int'(y), 0);
    run = 1'b0;
    #1;
    rst_n = 1'b1;
    step();

    // stop mid-dwell and resume
    digit_mask = 8'hFF;
    run        = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_tick(n, lows);
      chk($sformatf("run_a%0d", i), int'(a), i);
    end
    step();
    step();
    run = 1'b0;
    step();
    chk("halt_en", int'(en), 0);
    chk("halt_a", int'(a), 3);
    step();
    step();
    chk("halt_a2", int'(a), 3);
    chk("halt_y", int'(y), 0);
    run = 1'b1;
    wait_tick(n, lows);
    chk("resume_n", n, FIRST);
    chk("resume_a", int'(a), 4);
    chk("resume_y", int'(y), 8'h10);

    // zero mask
    digit_mask = 8'h00;
    step();
    chk("zero_en", int'(en), 0);
    ticks = 0;
    ens   = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (tick) ticks++;
      if (en) ens++;
    end
    chk("zero_ticks", ticks, 0);
    chk("zero_ens", ens, 0);
    chk("zero_a", int'(a), 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
